// File: rtl/fp_div_pkg.sv
// Shared types for the iterative floating-point divider.
package fp_div_pkg;

    localparam int EXTRA = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIV  = 3'd1,
        ST_NORM = 3'd2,
        ST_RND  = 3'd3,
        ST_SPEC = 3'd4
    } div_state_e;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic is_zero;
    } fp_class_t;

endpackage

// File: rtl/fp_div_mant.sv
// Restoring mantissa divider: one quotient bit per cycle, the first bit on the load edge.
module fp_div_mant #(
    parameter int MAN_W = 24,
    parameter int Q_W   = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [MAN_W-1:0] a_i,
    input  logic [MAN_W-1:0] b_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [Q_W-1:0]   q_o,
    output logic             sticky_o
);
    localparam int CNT_W = $clog2(Q_W + 1);

    logic [MAN_W:0]   rem_q;
    logic [MAN_W:0]   rem_d;
    logic [MAN_W-1:0] div_q;
    logic [Q_W-1:0]   q_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             valid_q;

    logic [MAN_W:0]   step_in_s;
    logic [MAN_W:0]   step_div_s;
    logic [MAN_W:0]   step_sub_s;
    logic             step_bit_s;

    // One restoring step; on load it works straight from the fresh operands.
    always_comb begin
        step_in_s  = rem_q;
        step_div_s = {1'b0, div_q};
        if (load_i) begin
            step_in_s  = {1'b0, a_i};
            step_div_s = {1'b0, b_i};
        end else begin
            step_in_s  = rem_q;
            step_div_s = {1'b0, div_q};
        end
        step_bit_s = (step_in_s >= step_div_s);
        step_sub_s = step_in_s - step_div_s;
        if (step_bit_s) begin
            rem_d = step_sub_s << 1;
        end else begin
            rem_d = step_in_s << 1;
        end
    end

    // Iteration state: remainder, quotient shift register and countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            rem_q   <= rem_d;
            div_q   <= b_i;
            q_q     <= {{(Q_W-1){1'b0}}, step_bit_s};
            cnt_q   <= CNT_W'(Q_W - 1);
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
        end else if (busy_q) begin
            rem_q <= rem_d;
            q_q   <= {q_q[Q_W-2:0], step_bit_s};
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign q_o      = q_q;
    assign sticky_o = (rem_q != '0);

endmodule

// File: rtl/fp_div.sv
// IEEE-754 divider with start/done handshake, RNE rounding and overflow/underflow/exception flags.
module fp_div
    import fp_div_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] res,
    output logic              overflow,
    output logic              underflow,
    output logic              exception
);
    localparam int MAN_W = DATA_W - EXP_W;
    localparam int BIAS  = 2**(EXP_W-1) - 1;
    localparam int Q_W   = MAN_W + EXTRA + 1;
    localparam int XE_W  = EXP_W + 2;
    localparam logic signed [XE_W-1:0] BIAS_X  = XE_W'(BIAS);
    localparam logic signed [XE_W-1:0] EXP_MAX = XE_W'(2**EXP_W - 1);
    localparam logic        [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-2:0] f);
        fp_class_t c;
        c.is_zero = (e == {EXP_W{1'b0}});
        c.is_inf  = (e == EXP_ONES) && (f == {(MAN_W-1){1'b0}});
        c.is_nan  = (e == EXP_ONES) && (f != {(MAN_W-1){1'b0}});
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] inf_val(input logic s);
        return {s, EXP_ONES, {(MAN_W-1){1'b0}}};
    endfunction

    div_state_e             state_q;
    logic                   busy_q, done_q, ovf_q, unf_q, exc_q;
    logic [DATA_W-1:0]      res_q, spec_res_q;
    logic                   spec_exc_q, sign_q;
    logic signed [XE_W-1:0] exp_q;
    logic [MAN_W-1:0]       mant_q;
    logic                   g_q, r_q, s_q;

    fp_class_t              cls_a_s, cls_b_s;
    logic                   sign_s, spec_s, spec_exc_s, load_s;
    logic [DATA_W-1:0]      spec_res_s;
    logic signed [XE_W-1:0] exp_diff_s;

    logic                   mant_busy_s, mant_valid_s, mant_sticky_s;
    logic [Q_W-1:0]         mant_quo_s;

    assign cls_a_s    = classify(op_a[DATA_W-2 -: EXP_W], op_a[MAN_W-2:0]);
    assign cls_b_s    = classify(op_b[DATA_W-2 -: EXP_W], op_b[MAN_W-2:0]);
    assign sign_s     = op_a[DATA_W-1] ^ op_b[DATA_W-1];
    assign exp_diff_s = $signed({2'b00, op_a[DATA_W-2 -: EXP_W]})
                      - $signed({2'b00, op_b[DATA_W-2 -: EXP_W]}) + BIAS_X;

    // Special-operand screening; subnormals already count as zero in classify.
    always_comb begin
        spec_s     = 1'b1;
        spec_exc_s = 1'b0;
        spec_res_s = {sign_s, {(DATA_W-1){1'b0}}};
        if (cls_a_s.is_nan || cls_b_s.is_nan ||
            (cls_a_s.is_inf && cls_b_s.is_inf) || (cls_a_s.is_zero && cls_b_s.is_zero)) begin
            spec_res_s = {1'b0, EXP_ONES, 1'b1, {(MAN_W-2){1'b0}}};
            spec_exc_s = 1'b1;
        end else if (cls_b_s.is_zero && !cls_a_s.is_inf) begin
            spec_res_s = inf_val(sign_s);
            spec_exc_s = 1'b1;
        end else if (cls_a_s.is_inf) begin
            spec_res_s = inf_val(sign_s);
        end else if (cls_b_s.is_inf || cls_a_s.is_zero) begin
            spec_res_s = {sign_s, {(DATA_W-1){1'b0}}};
        end else begin
            spec_s = 1'b0;
        end
    end

    assign load_s = (state_q == ST_IDLE) && start && !spec_s;

    fp_div_mant #(.MAN_W(MAN_W), .Q_W(Q_W)) u_mant (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_s),
        .a_i      ({1'b1, op_a[MAN_W-2:0]}),
        .b_i      ({1'b1, op_b[MAN_W-2:0]}),
        .busy_o   (mant_busy_s),
        .valid_o  (mant_valid_s),
        .q_o      (mant_quo_s),
        .sticky_o (mant_sticky_s)
    );

    logic [MAN_W-1:0]       norm_mant_s;
    logic                   norm_g_s, norm_r_s, norm_s_s;
    logic signed [XE_W-1:0] norm_exp_s;

    // Normalize the quotient, which lies in [0.5, 2) of its leading weight.
    always_comb begin
        if (mant_quo_s[Q_W-1]) begin
            norm_mant_s = mant_quo_s[Q_W-1 -: MAN_W];
            norm_g_s    = mant_quo_s[3];
            norm_r_s    = mant_quo_s[2];
            norm_s_s    = mant_quo_s[1] | mant_quo_s[0] | mant_sticky_s;
            norm_exp_s  = exp_q;
        end else begin
            norm_mant_s = mant_quo_s[Q_W-2 -: MAN_W];
            norm_g_s    = mant_quo_s[2];
            norm_r_s    = mant_quo_s[1];
            norm_s_s    = mant_quo_s[0] | mant_sticky_s;
            norm_exp_s  = exp_q - XE_W'(1);
        end
    end

    logic                   rnd_inc_s, rnd_ovf_s, rnd_unf_s;
    logic [MAN_W:0]         rnd_sum_s;
    logic [MAN_W-2:0]       rnd_frac_s;
    logic signed [XE_W-1:0] rnd_exp_s;
    logic [DATA_W-1:0]      rnd_res_s;

    // Round to nearest even, then range-check the final exponent.
    always_comb begin
        rnd_inc_s = g_q & (r_q | s_q | mant_q[0]);
        rnd_sum_s = {1'b0, mant_q} + {{MAN_W{1'b0}}, rnd_inc_s};
        if (rnd_sum_s[MAN_W]) begin
            rnd_frac_s = rnd_sum_s[MAN_W-1:1];
            rnd_exp_s  = exp_q + XE_W'(1);
        end else begin
            rnd_frac_s = rnd_sum_s[MAN_W-2:0];
            rnd_exp_s  = exp_q;
        end
        rnd_ovf_s = 1'b0;
        rnd_unf_s = 1'b0;
        if (rnd_exp_s >= EXP_MAX) begin
            rnd_res_s = inf_val(sign_q);
            rnd_ovf_s = 1'b1;
        end else if (rnd_exp_s <= $signed({XE_W{1'b0}})) begin
            rnd_res_s = {sign_q, {(DATA_W-1){1'b0}}};
            rnd_unf_s = 1'b1;
        end else begin
            rnd_res_s = {sign_q, rnd_exp_s[EXP_W-1:0], rnd_frac_s};
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            exc_q      <= 1'b0;
            spec_res_q <= '0;
            spec_exc_q <= 1'b0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            g_q        <= 1'b0;
            r_q        <= 1'b0;
            s_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q     <= 1'b1;
                        sign_q     <= sign_s;
                        exp_q      <= exp_diff_s;
                        spec_res_q <= spec_res_s;
                        spec_exc_q <= spec_exc_s;
                        state_q    <= spec_s ? ST_SPEC : ST_DIV;
                    end
                end
                ST_SPEC: begin
                    res_q   <= spec_res_q;
                    ovf_q   <= 1'b0;
                    unf_q   <= 1'b0;
                    exc_q   <= spec_exc_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_DIV: begin
                    if (mant_valid_s && !mant_busy_s) begin
                        state_q <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    mant_q  <= norm_mant_s;
                    g_q     <= norm_g_s;
                    r_q     <= norm_r_s;
                    s_q     <= norm_s_s;
                    exp_q   <= norm_exp_s;
                    state_q <= ST_RND;
                end
                ST_RND: begin
                    res_q   <= rnd_res_s;
                    ovf_q   <= rnd_ovf_s;
                    unf_q   <= rnd_unf_s;
                    exc_q   <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign res       = res_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign exception = exc_q;

endmodule

// File: tb/tb_fp_div.sv
// Directed-vector bench for fp_div: results, flags, latency, busy and abort behaviour.
module tb_fp_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic        busy, done, overflow, underflow, exception;
    logic [31:0] res;

    int n_vec = 0;
    int n_err = 0;

    fp_div dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .res       (res),
        .overflow  (overflow),
        .underflow (underflow),
        .exception (exception)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] flags();
        return {29'd0, overflow, underflow, exception};
    endfunction

    // Called #1 after a clock edge; start is presented immediately.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want, input logic [2:0] want_flags, input int want_lat);
        int   lat;
        logic busy_ok;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        op_a    = 32'h0;
        op_b    = 32'h0;
        busy_ok = busy;
        lat     = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        chk({tag, "/lat"}, 32'(lat), 32'(want_lat));
        chk({tag, "/res"}, res, want);
        chk({tag, "/flags"}, flags(), {29'd0, want_flags});
        chk({tag, "/busy"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, "/busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n_done;
        int first_lat;
        logic [31:0] first_res;

        repeat (2) @(posedge clk);
        #1;
        chk("reset/busy", {31'd0, busy}, 32'd0);
        chk("reset/done", {31'd0, done}, 32'd0);
        chk("reset/res", res, 32'h0);
        chk("reset/flags", flags(), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("6div2",     32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 30);
        run_op("1div3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 30);
        run_op("1div1",     32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 30);
        run_op("neg6div2",  32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000, 30);
        run_op("1div0",     32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, 1);
        run_op("m1div0",    32'hBF800000, 32'h00000000, 32'hFF800000, 3'b001, 1);
        run_op("0div0",     32'h00000000, 32'h00000000, 32'h7FC00000, 3'b001, 1);
        run_op("infdivinf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b001, 1);
        run_op("nandiv1",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001, 1);
        run_op("2divinf",   32'h40000000, 32'h7F800000, 32'h00000000, 3'b000, 1);
        run_op("subnorm",   32'h00000001, 32'h3F800000, 32'h00000000, 3'b000, 1);
        run_op("ovf",       32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, 30);
        run_op("unf",       32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 30);

        // A second start while busy is dropped.
        op_a  = 32'h40C00000;
        op_b  = 32'h40000000;
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        n_done    = 0;
        first_lat = 0;
        first_res = 32'h0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    first_lat = i;
                    first_res = res;
                end
            end
            if (i == 4) begin
                op_a  = 32'h3F800000;
                op_b  = 32'h40400000;
                start = 1'b1;
            end
        end
        chk("busy_start/n_done", 32'(n_done), 32'd1);
        chk("busy_start/lat", 32'(first_lat), 32'd30);
        chk("busy_start/res", first_res, 32'h40400000);

        // Reset mid-operation aborts with no done, then a new start is accepted.
        op_a  = 32'h3F800000;
        op_b  = 32'h40400000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort/busy", {31'd0, busy}, 32'd0);
        chk("abort/done", {31'd0, done}, 32'd0);
        chk("abort/res", res, 32'h0);
        chk("abort/flags", flags(), 32'd0);
        run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
